// File: rtl/way_data_array_pkg.sv
// Shared types and helpers for the N-way cache data array.
//   wda_state_e  : clear-engine state (CLEAR sweeps the array, IDLE serves ports)
//   s_mask()     : bytes per line for a given log2 line size
//   s_line()     : bits per line for a given log2 line size
//   byte_parity(): even-parity bit for one byte
package way_data_array_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } wda_state_e;

    function automatic int s_mask(input int s_offset);
        return 2 ** s_offset;
    endfunction

    function automatic int s_line(input int s_offset);
        return 8 * (2 ** s_offset);
    endfunction

    // Stored alongside each byte so that byte + parity has an even number
    // of ones; a zero byte therefore carries parity 0.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/data_way_bank.sv
// One way of the data array: NUM_SETS lines with per-byte masked write,
// set-wide clear and a combinational read with per-byte write bypass.
// Optional parity storage is enabled by WAY_DATA_ARRAY_PARITY_EN.
// Ports:
//   clk_i        clock
//   clr_i        zero line clr_index_i (and its parity) this cycle
//   clr_index_i  set being cleared
//   wmask_i      per-byte write enable, already gated for this way
//   windex_i     write set
//   wdata_i      write data
//   rindex_i     read set
//   bypass_i     read set equals write set this cycle
//   rdata_o      read line, masked bytes replaced by wdata_i when bypassing
//   rerr_o       any non-bypassed byte of the read line fails parity
module data_way_bank
    import way_data_array_pkg::*;
#(
    parameter int S_OFFSET = 5,
    parameter int S_INDEX  = 3
) (
    input  logic                          clk_i,
    input  logic                          clr_i,
    input  logic [S_INDEX-1:0]            clr_index_i,
    input  logic [s_mask(S_OFFSET)-1:0]   wmask_i,
    input  logic [S_INDEX-1:0]            windex_i,
    input  logic [s_line(S_OFFSET)-1:0]   wdata_i,
    input  logic [S_INDEX-1:0]            rindex_i,
    input  logic                          bypass_i,
    output logic [s_line(S_OFFSET)-1:0]   rdata_o,
    output logic                          rerr_o
);

    localparam int S_MASK   = s_mask(S_OFFSET);
    localparam int S_LINE   = s_line(S_OFFSET);
    localparam int NUM_SETS = 2 ** S_INDEX;

    // No reset on storage: the clear engine zeroes it after reset.
    logic [S_LINE-1:0] mem_q [NUM_SETS];

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            mem_q[clr_index_i] <= '0;
        end else begin
            for (int i = 0; i < S_MASK; i++) begin
                if (wmask_i[i]) begin
                    mem_q[windex_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rdata_o = mem_q[rindex_i];
        for (int i = 0; i < S_MASK; i++) begin
            if (bypass_i && wmask_i[i]) begin
                rdata_o[8*i +: 8] = wdata_i[8*i +: 8];
            end
        end
    end

`ifdef WAY_DATA_ARRAY_PARITY_EN
    logic [S_MASK-1:0] par_q [NUM_SETS];

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            par_q[clr_index_i] <= '0;
        end else begin
            for (int i = 0; i < S_MASK; i++) begin
                if (wmask_i[i]) begin
                    par_q[windex_i][i] <= byte_parity(wdata_i[8*i +: 8]);
                end
            end
        end
    end

    // Bypassed bytes come straight from wdata_i with fresh parity, so only
    // bytes actually read from storage can flag.
    always_comb begin
        rerr_o = 1'b0;
        for (int i = 0; i < S_MASK; i++) begin
            if (!(bypass_i && wmask_i[i]) &&
                (byte_parity(mem_q[rindex_i][8*i +: 8]) != par_q[rindex_i][i])) begin
                rerr_o = 1'b1;
            end
        end
    end
`else
    assign rerr_o = 1'b0;
`endif

endmodule

// File: rtl/way_data_array.sv
// N-way cache data array with per-byte write masks, one-cycle registered
// read of all ways, same-cycle write bypass and a one-set-per-cycle clear
// engine that runs after reset or on request.
// Optional per-byte parity: define WAY_DATA_ARRAY_PARITY_EN.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clear         request a full clear (ignored while already clearing)
//   ready         array accepts reads and writes
//   read, rindex  read request and set
//   rvalid        dataout/rerr valid this cycle
//   dataout       all ways of the read set, way w at [w*S_LINE +: S_LINE]
//   rerr          per-way parity error, qualified by rvalid
//   wmask, wway, windex, datain   masked byte write
//   dbg_state_o   clear-engine state
// Handshake: there is no backpressure. A read or write is taken in any
// cycle where ready is high (a write is dropped if clear is also high);
// a taken read returns rvalid=1 exactly one cycle later.
module way_data_array
    import way_data_array_pkg::*;
#(
    parameter int S_OFFSET = 5,
    parameter int S_INDEX  = 3,
    parameter int S_WAY    = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     clear,
    output logic                                     ready,
    input  logic                                     read,
    input  logic [S_INDEX-1:0]                       rindex,
    output logic                                     rvalid,
    output logic [(2**S_WAY)*s_line(S_OFFSET)-1:0]   dataout,
    output logic [(2**S_WAY)-1:0]                    rerr,
    input  logic [s_mask(S_OFFSET)-1:0]              wmask,
    input  logic [S_WAY-1:0]                         wway,
    input  logic [S_INDEX-1:0]                       windex,
    input  logic [s_line(S_OFFSET)-1:0]              datain,
    output wda_state_e                               dbg_state_o
);

    localparam int S_MASK   = s_mask(S_OFFSET);
    localparam int S_LINE   = s_line(S_OFFSET);
    localparam int NUM_SETS = 2 ** S_INDEX;
    localparam int NUM_WAYS = 2 ** S_WAY;

    wda_state_e           state_q, state_d;
    logic [S_INDEX-1:0]   cnt_q, cnt_d;
    logic                 clr_en, wr_en, rd_en;

    logic                        rvalid_q;
    logic [NUM_WAYS*S_LINE-1:0]  dout_q;
    logic [NUM_WAYS-1:0]         rerr_q;

    logic [NUM_WAYS*S_LINE-1:0]  rd_data;
    logic [NUM_WAYS-1:0]         rd_err;
    logic                        bypass;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_en  = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        ready   = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_en = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == S_INDEX'(NUM_SETS - 1)) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                ready = 1'b1;
                rd_en = read;
                if (clear) begin
                    // The read in this cycle is still served; the write is not.
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else begin
                    wr_en = 1'b1;
                end
            end
        endcase
    end

    assign dbg_state_o = state_q;
    assign bypass      = (rindex == windex);

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        logic [S_MASK-1:0] way_mask;

        assign way_mask = (wr_en && (int'(wway) == w)) ? wmask : '0;

        data_way_bank #(
            .S_OFFSET (S_OFFSET),
            .S_INDEX  (S_INDEX)
        ) u_bank (
            .clk_i       (clk),
            .clr_i       (clr_en),
            .clr_index_i (cnt_q),
            .wmask_i     (way_mask),
            .windex_i    (windex),
            .wdata_i     (datain),
            .rindex_i    (rindex),
            .bypass_i    (bypass),
            .rdata_o     (rd_data[w*S_LINE +: S_LINE]),
            .rerr_o      (rd_err[w])
        );
    end

    // dataout and rerr hold their last value when no read is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            dout_q   <= '0;
            rerr_q   <= '0;
        end else begin
            rvalid_q <= rd_en;
            if (rd_en) begin
                dout_q <= rd_data;
                rerr_q <= rd_err;
            end
        end
    end

    assign rvalid  = rvalid_q;
    assign dataout = dout_q;
    assign rerr    = rerr_q;

endmodule

// File: tb/tb_way_data_array.sv
module tb_way_data_array;
    import way_data_array_pkg::*;

    localparam int S_OFFSET = 5;
    localparam int S_INDEX  = 3;
    localparam int S_WAY    = 2;
    localparam int S_MASK   = 2 ** S_OFFSET;
    localparam int S_LINE   = 8 * S_MASK;
    localparam int NUM_SETS = 2 ** S_INDEX;
    localparam int NUM_WAYS = 2 ** S_WAY;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                        clear = 1'b0;
    logic                        ready;
    logic                        read = 1'b0;
    logic [S_INDEX-1:0]          rindex = '0;
    logic                        rvalid;
    logic [NUM_WAYS*S_LINE-1:0]  dataout;
    logic [NUM_WAYS-1:0]         rerr;
    logic [S_MASK-1:0]           wmask = '0;
    logic [S_WAY-1:0]            wway = '0;
    logic [S_INDEX-1:0]          windex = '0;
    logic [S_LINE-1:0]           datain = '0;
    wda_state_e                  dbg_state;

    way_data_array #(
        .S_OFFSET (S_OFFSET),
        .S_INDEX  (S_INDEX),
        .S_WAY    (S_WAY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .ready       (ready),
        .read        (read),
        .rindex      (rindex),
        .rvalid      (rvalid),
        .dataout     (dataout),
        .rerr        (rerr),
        .wmask       (wmask),
        .wway        (wway),
        .windex      (windex),
        .datain      (datain),
        .dbg_state_o (dbg_state)
    );

    // ---------------- reference model / scoreboard ----------------
    int errors = 0;
    int checks = 0;

    logic [S_LINE-1:0]           model   [NUM_WAYS][NUM_SETS];
    logic [S_MASK-1:0]           corrupt [NUM_WAYS][NUM_SETS];
    logic [NUM_WAYS*S_LINE-1:0]  exp_q [$];
    logic [NUM_WAYS-1:0]         err_q [$];
    logic [NUM_WAYS*S_LINE-1:0]  last_dout;
    int                          sweep_left;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [S_LINE-1:0] obs,
                         input logic [S_LINE-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic zero_model();
        for (int w = 0; w < NUM_WAYS; w++)
            for (int s = 0; s < NUM_SETS; s++) begin
                model[w][s]   = '0;
                corrupt[w][s] = '0;
            end
    endtask

    function automatic logic [S_LINE-1:0] rand_line();
        logic [S_LINE-1:0] ln;
        for (int i = 0; i < S_LINE / 32; i++) ln[32*i +: 32] = $urandom;
        return ln;
    endfunction

    task automatic do_reset();
        rst = 1'b1; read = 1'b0; clear = 1'b0; wmask = '0;
        tick();
        rst = 1'b0;
        sweep_left = NUM_SETS;
        last_dout  = '0;
        zero_model();
        check("rst_ready", S_LINE'(ready), '0);
        check("rst_rvalid", S_LINE'(rvalid), '0);
        check("rst_rerr", S_LINE'(rerr), '0);
        for (int w = 0; w < NUM_WAYS; w++)
            check($sformatf("rst_dout_w%0d", w), dataout[w*S_LINE +: S_LINE], '0);
    endtask

    // One clock cycle of port activity, checked against the model.
    task automatic step(input logic rd, input logic [S_INDEX-1:0] ri,
                        input logic [S_MASK-1:0] wm, input logic [S_WAY-1:0] ww,
                        input logic [S_INDEX-1:0] wi, input logic [S_LINE-1:0] wd,
                        input logic clr);
        logic rd_ok, wr_ok;
        logic [NUM_WAYS*S_LINE-1:0] exp_line;
        logic [NUM_WAYS-1:0] exp_err;
        logic [S_LINE-1:0] ln;
        logic [S_MASK-1:0] bad;
        read = rd; rindex = ri; wmask = wm; wway = ww; windex = wi; datain = wd; clear = clr;
        check("ready", S_LINE'(ready), S_LINE'(sweep_left == 0));
        rd_ok = (sweep_left == 0) && rd;
        wr_ok = (sweep_left == 0) && !clr;
        if (rd_ok) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                ln  = model[w][ri];
                bad = corrupt[w][ri];
                if (wr_ok && ri == wi && int'(ww) == w)
                    for (int b = 0; b < S_MASK; b++)
                        if (wm[b]) begin
                            ln[8*b +: 8] = wd[8*b +: 8];
                            bad[b] = 1'b0;
                        end
                exp_line[w*S_LINE +: S_LINE] = ln;
                exp_err[w] = |bad;
            end
            exp_q.push_back(exp_line);
            err_q.push_back(exp_err);
        end
        tick();
        if (wr_ok)
            for (int b = 0; b < S_MASK; b++)
                if (wm[b]) begin
                    model[ww][wi][8*b +: 8] = wd[8*b +: 8];
                    corrupt[ww][wi][b] = 1'b0;
                end
        if (sweep_left > 0) begin
            sweep_left--;
            if (sweep_left == 0) zero_model();
        end else if (clr) begin
            sweep_left = NUM_SETS;
        end
        check("rvalid", S_LINE'(rvalid), S_LINE'(rd_ok));
        if (rd_ok) begin
            last_dout = exp_q.pop_front();
            exp_err   = err_q.pop_front();
            check("rerr", S_LINE'(rerr), S_LINE'(exp_err));
        end
        for (int w = 0; w < NUM_WAYS; w++)
            check($sformatf("dout_w%0d", w), dataout[w*S_LINE +: S_LINE],
                  last_dout[w*S_LINE +: S_LINE]);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        logic [S_LINE-1:0] d;

        do_reset();
        // ready must stay low for exactly NUM_SETS cycles (checked in step)
        repeat (NUM_SETS) step(1'b0, '0, '0, '0, '0, '0, 1'b0);
        step(1'b1, 3'd5, '0, '0, '0, '0, 1'b0);
        check("set5_zero", S_LINE'(dataout != '0), '0);

        // Masked write then read back
        d = '0; d[31:0] = 32'hDEADBEEF;
        step(1'b0, '0, 32'h0000_000F, 2'd2, 3'd3, d, 1'b0);
        step(1'b1, 3'd3, '0, '0, '0, '0, 1'b0);
        check("w2_low_word", S_LINE'(dataout[2*S_LINE +: 32]), S_LINE'(32'hDEADBEEF));

        // Bypass on same set, none on a different set
        d = rand_line(); d[7:0] = 8'hAA;
        step(1'b1, 3'd6, 32'h1, 2'd1, 3'd6, d, 1'b0);
        check("bypass_byte", S_LINE'(dataout[S_LINE +: 8]), S_LINE'(8'hAA));
        d[7:0] = 8'hBB;
        step(1'b1, 3'd7, 32'h1, 2'd1, 3'd6, d, 1'b0);
        check("no_bypass", S_LINE'(dataout[S_LINE +: 8]), '0);
        step(1'b1, 3'd6, '0, '0, '0, '0, 1'b0);
        check("set6_written", S_LINE'(dataout[S_LINE +: 8]), S_LINE'(8'hBB));

        // Fill, clear with reads during the sweep, read back zero
        for (int s = 0; s < NUM_SETS; s++)
            for (int w = 0; w < NUM_WAYS; w++)
                step(1'b0, '0, '1, S_WAY'(w), S_INDEX'(s), rand_line(), 1'b0);
        step(1'b1, 3'd2, '1, 2'd0, 3'd2, rand_line(), 1'b1);
        repeat (NUM_SETS) step(1'b1, 3'($urandom_range(0, 7)), '1, 2'd1, 3'd4, rand_line(),
                               1'($urandom_range(0, 1)));
        for (int s = 0; s < NUM_SETS; s++) step(1'b1, S_INDEX'(s), '0, '0, '0, '0, 1'b0);

        // Refill, clear, then reset at sweep cycle 4
        for (int s = 0; s < NUM_SETS; s++)
            step(1'b0, '0, '1, 2'd3, S_INDEX'(s), rand_line(), 1'b0);
        step(1'b0, '0, '0, '0, '0, '0, 1'b1);
        repeat (4) step(1'b1, 3'd1, '1, 2'd0, 3'd1, rand_line(), 1'b0);
        do_reset();
        repeat (NUM_SETS) step(1'b1, 3'd0, '1, 2'd0, 3'd0, rand_line(), 1'b0);
        for (int s = 0; s < NUM_SETS; s++) step(1'b1, S_INDEX'(s), '0, '0, '0, '0, 1'b0);

`ifdef WAY_DATA_ARRAY_PARITY_EN
        d = '0; d[7:0] = 8'h55;
        step(1'b0, '0, 32'h1, 2'd0, 3'd1, d, 1'b0);
        dut.g_way[0].u_bank.mem_q[1][0] = ~dut.g_way[0].u_bank.mem_q[1][0];
        model[0][1][0]   = ~model[0][1][0];
        corrupt[0][1][0] = 1'b1;
        step(1'b1, 3'd1, '0, '0, '0, '0, 1'b0);
        check("parity_flag", S_LINE'(rerr), S_LINE'(4'b0001));
        d[7:0] = 8'h3C;
        step(1'b1, 3'd1, 32'h1, 2'd0, 3'd1, d, 1'b0);
        check("parity_bypass", S_LINE'(rerr), '0);
`endif

        // Randomized traffic with occasional clear requests
        repeat (300) begin
            logic [S_INDEX-1:0] ri;
            ri = S_INDEX'($urandom_range(0, NUM_SETS - 1));
            step(1'($urandom_range(0, 1)), ri,
                 ($urandom_range(0, 3) == 0) ? '0 : S_MASK'($urandom),
                 S_WAY'($urandom_range(0, NUM_WAYS - 1)),
                 ($urandom_range(0, 1) == 1) ? ri : S_INDEX'($urandom_range(0, NUM_SETS - 1)),
                 rand_line(), ($urandom_range(0, 39) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/way_data_array.md
# way_data_array

Parametrised N-way successor to the cache's single-way data array. It holds `NUM_WAYS` ways of `2**S_OFFSET`-byte lines across `2**S_INDEX` sets, with per-byte write masks and a one-cycle registered read of every way. Writes bypass to a same-cycle read, and a sequential clear engine zeroes the array one set per cycle after reset or on request. It sits between the cache controller (tag compare / way select) and the line-fill datapath.

## Interface
- `S_OFFSET`, default 5: log2 bytes per line; `S_MASK = 2**S_OFFSET`, `S_LINE = 8*S_MASK`.
- `S_INDEX`, default 3: log2 sets; `NUM_SETS = 2**S_INDEX`.
- `S_WAY`, default 2: log2 ways; `NUM_WAYS = 2**S_WAY`.
- `clk`  in  1  sole clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `clear`  in  1  request a full array clear (pulse).
- `ready`  out  1  high when the array accepts reads and writes.
- `read`  in  1  read request for `rindex`.
- `rindex`  in  `S_INDEX`  read set.
- `rvalid`  out  1  `dataout` valid this cycle.
- `dataout`  out  `NUM_WAYS*S_LINE`  way w at bits [w*S_LINE +: S_LINE].
- `rerr`  out  `NUM_WAYS`  per-way parity error, qualified by `rvalid`.
- `wmask`  in  `S_MASK`  per-byte write enable; all-zero means no write.
- `wway`  in  `S_WAY`  write way.
- `windex`  in  `S_INDEX`  write set.
- `datain`  in  `S_LINE`  write data.

## Operation
- States: `CLEAR`, `IDLE`. `rst` forces `CLEAR` with the counter at 0.
- `CLEAR`:
  - Each cycle writes zero to all ways of set `cnt`, then increments `cnt`.
  - After set `NUM_SETS-1` it moves to `IDLE`.
  - `ready`=0. `read` and `wmask` are ignored; no array update from ports.
- `IDLE` and `clear`=1: go to `CLEAR`, `cnt`=0. A same-cycle port write is dropped. A same-cycle read is still served.
- `clear` while in `CLEAR` is ignored; the sweep does not restart.
- `rst` mid-clear restarts the sweep at set 0.
- Write (`IDLE`): for each i with `wmask[i]`=1, byte i of `data[wway][windex]` ← `datain[8i+:8]`. Other bytes are unchanged.
- Read (`IDLE`, `read`=1): next cycle `dataout` holds all ways of `rindex` and `rvalid`=1.
- Bypass: if the read and a write are in the same cycle with `rindex`==`windex`, the masked bytes of way `wway` in `dataout` come from `datain`. All other bytes and ways come from the array.
- `read`=0: `dataout` holds its last value; `rvalid`=0.
- Reset values: `ready`=0, `rvalid`=0, `dataout`=0, `rerr`=0. Array contents are undefined until the sweep finishes, then zero.

## Timing
- Read latency is exactly 1 cycle; one read per cycle at full throughput.
- Write lands at the edge: a read of that set/way in the next cycle sees the new bytes.
- Clear takes `NUM_SETS` cycles. `ready` rises on the cycle after the last set is written. With the defaults, reset release + 8 cycles.
- No backpressure. The requester gates on `ready` only.

## Configuration
- `WAY_DATA_ARRAY_PARITY_EN` defined:
  - One even-parity bit is stored per byte and written with it. Clear writes parity 0.
  - On read, `rerr[w]`=1 when any byte of way w mismatches its parity.
  - Bypassed bytes use parity computed from `datain`, so they never flag.
- `WAY_DATA_ARRAY_PARITY_EN` undefined: no parity storage; `rerr` is tied to 0.

## Structure
- Package `way_data_array_pkg` holds:
  - the state enum `wda_state_e {CLEAR, IDLE}`;
  - the `S_MASK`/`S_LINE` helper functions;
  - the byte-parity function.
- Sub-module `data_way_bank`: one way's storage (data plus optional parity) with masked write and per-byte bypass, instantiated `NUM_WAYS` times.
- The clear FSM and the read register stay in the top module.

## Test plan
- Reset, then hold `rst`=1 for 1 cycle and release → `ready`=0 for 8 cycles, then 1. Read set 5 → all ways 0, `rerr`=0.
- Write way 2, set 3, `wmask`=0x0000000F, `datain` bytes 0..3 = 0xDEADBEEF; next cycle read set 3 → way 2 low word 0xDEADBEEF, rest 0, other ways 0.
- Same-cycle write way 1, set 6, `wmask`=0x1 with byte 0xAA, plus read set 6 → the next cycle's `dataout` way 1 byte 0 = 0xAA (bypass). A write/read with different sets → no bypass.
- Fill all sets, pulse `clear`, and assert `read` during the sweep → `rvalid`=0 throughout. After 8 cycles `ready`=1 and every set reads 0. Pulse `rst` at sweep cycle 4 → sweep restarts, `ready` at +8 from the `rst` release.
- `WAY_DATA_ARRAY_PARITY_EN`: force-flip a stored bit of way 0, set 1 → read set 1 gives `rerr`=4'b0001. The same read with a bypassing write over that byte gives `rerr`=0.
